// File: rtl/spi_byte_queue_pkg.sv
// Shared definitions for the SPI byte queue: FSM state codes and
// the default FIFO depth used by the top module.
package spi_byte_queue_pkg;

   localparam int DEFAULT_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_DONE = 2'b01,
      GAP       = 2'b10
   } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// Ports: push/wdata write, pop/rdata read (rdata 0 when empty),
// empty/full status. A push while full only lands if a pop
// happens in the same cycle; a pop while empty is ignored.
module spi_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);
   assign pop_ok  = pop & ~empty;
   // The slot freed by a same-cycle pop makes room at full.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = empty ? 8'h00 : mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/spi_byte_queue.sv
// Byte queue in front of an SPI byte engine: TX FIFO feeds the
// engine one byte per start/done handshake, results go to RX FIFO.
// Ports: tx_write/tx_wdata/tx_full, rx_read/rx_rdata/rx_empty,
// cs_assert/cs_release -> spi_cs_n, busy, and the engine handshake
// spi_start/spi_data_in out, spi_done/spi_data_out in.
module spi_byte_queue
   import spi_byte_queue_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_write,
   input  logic [7:0] tx_wdata,
   output logic       tx_full,
   input  logic       rx_read,
   output logic [7:0] rx_rdata,
   output logic       rx_empty,
   input  logic       cs_assert,
   input  logic       cs_release,
   output logic       busy,
   output logic       spi_start,
   output logic [7:0] spi_data_in,
   input  logic       spi_done,
   input  logic [7:0] spi_data_out,
   output logic       spi_cs_n
);

   state_t     state_q;
   logic       start_q;
   logic [7:0] data_q;
   logic       cs_n_q;
   logic       done_q;

   logic [7:0] tx_rdata;
   logic       tx_empty;
   logic       rx_full;
   logic       tx_pop;
   logic       rx_push;
   logic       done_rise;

   // Only a fresh done counts: an engine lingering in its done
   // state must not produce a second push for the next byte.
   assign done_rise = spi_done & ~done_q;
   assign tx_pop    = (state_q == IDLE) & ~tx_empty & ~rx_full;
   assign rx_push   = (state_q == WAIT_DONE) & done_rise;

   assign busy        = ~tx_empty | (state_q != IDLE);
   assign spi_start   = start_q;
   assign spi_data_in = data_q;
   assign spi_cs_n    = cs_n_q;

   spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (clk),
      .reset (reset),
      .push  (tx_write),
      .wdata (tx_wdata),
      .pop   (tx_pop),
      .rdata (tx_rdata),
      .empty (tx_empty),
      .full  (tx_full)
   );

   spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .wdata (spi_data_out),
      .pop   (rx_read),
      .rdata (rx_rdata),
      .empty (rx_empty),
      .full  (rx_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         data_q  <= 8'h00;
         cs_n_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= spi_done;
         if (cs_release)     cs_n_q <= 1'b1;
         else if (cs_assert) cs_n_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_pop) begin
                  data_q  <= tx_rdata;
                  start_q <= 1'b1;
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (done_rise) begin
                  start_q <= 1'b0;
                  state_q <= GAP;
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               start_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_byte_queue.sv
// Self-checking bench for spi_byte_queue with a loopback engine
// model whose latency and done-hold length are adjustable.
module tb_spi_byte_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_write;
   logic [7:0] tx_wdata;
   logic       tx_full;
   logic       rx_read;
   logic [7:0] rx_rdata;
   logic       rx_empty;
   logic       cs_assert;
   logic       cs_release;
   logic       busy;
   logic       spi_start;
   logic [7:0] spi_data_in;
   logic       spi_done;
   logic [7:0] spi_data_out;
   logic       spi_cs_n;

   always #5 clk = ~clk;

   spi_byte_queue #(.FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_write     (tx_write),
      .tx_wdata     (tx_wdata),
      .tx_full      (tx_full),
      .rx_read      (rx_read),
      .rx_rdata     (rx_rdata),
      .rx_empty     (rx_empty),
      .cs_assert    (cs_assert),
      .cs_release   (cs_release),
      .busy         (busy),
      .spi_start    (spi_start),
      .spi_data_in  (spi_data_in),
      .spi_done     (spi_done),
      .spi_data_out (spi_data_out),
      .spi_cs_n     (spi_cs_n)
   );

   // Engine model: latch byte on start, wait eng_lat cycles, then
   // raise done for eng_hold cycles returning the same byte.
   int         eng_lat  = 2;
   int         eng_hold = 1;
   int         eng_st;
   int         eng_cnt;
   int         eng_hcnt;
   logic [7:0] eng_byte;

   always @(posedge clk) begin
      if (reset) begin
         eng_st       <= 0;
         spi_done     <= 1'b0;
         spi_data_out <= 8'h00;
      end else begin
         case (eng_st)
            0: if (spi_start) begin
               eng_byte <= spi_data_in;
               eng_cnt  <= eng_lat;
               eng_st   <= 1;
            end
            1: if (eng_cnt == 0) begin
               spi_done     <= 1'b1;
               spi_data_out <= eng_byte;
               eng_hcnt     <= eng_hold - 1;
               eng_st       <= 2;
            end else begin
               eng_cnt <= eng_cnt - 1;
            end
            2: if (eng_hcnt == 0) begin
               spi_done <= 1'b0;
               eng_st   <= 3;
            end else begin
               eng_hcnt <= eng_hcnt - 1;
            end
            default: eng_st <= 0;
         endcase
      end
   end

   // Start-gap monitor: shortest low run between start rises.
   logic mon_en = 1'b0;
   logic mon_prev = 1'b0;
   int   mon_rises;
   int   mon_low;
   int   mon_min;

   always @(negedge clk) begin
      if (!mon_en) begin
         mon_rises = 0;
         mon_low   = 0;
         mon_min   = 99;
      end else begin
         if (spi_start && !mon_prev) begin
            if (mon_rises > 0 && mon_low < mon_min) mon_min = mon_low;
            mon_rises = mon_rises + 1;
         end
         if (spi_start) mon_low = 0;
         else           mon_low = mon_low + 1;
      end
      mon_prev = spi_start;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget && busy; i++) tick();
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_start(input string name, input int budget);
      for (int i = 0; i < budget && !spi_start; i++) tick();
      check(name, 32'(spi_start), 32'd1);
   endtask

   task automatic read_expect(input string name, input logic [7:0] exp);
      for (int i = 0; i < 100 && rx_empty; i++) tick();
      check(name, 32'(rx_rdata), 32'(exp));
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
   endtask

   typedef struct {
      logic a;
      logic r;
      logic exp_cs_n;
   } cs_vec_t;

   typedef struct {
      logic [7:0] wdata;
      logic [7:0] exp_rx;
   } byte_vec_t;

   cs_vec_t    cs_tab [6];
   byte_vec_t  fill_tab [8];
   logic [7:0] drain_q [$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit stalled;

      cs_tab[0] = '{1'b1, 1'b0, 1'b0};
      cs_tab[1] = '{1'b0, 1'b0, 1'b0};
      cs_tab[2] = '{1'b1, 1'b1, 1'b1};
      cs_tab[3] = '{1'b1, 1'b0, 1'b0};
      cs_tab[4] = '{1'b0, 1'b1, 1'b1};
      cs_tab[5] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++)
         fill_tab[i] = '{8'(8'h10 + i), 8'(8'h10 + i)};

      reset      = 1'b1;
      tx_write   = 1'b0;
      tx_wdata   = 8'h00;
      rx_read    = 1'b0;
      cs_assert  = 1'b0;
      cs_release = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_tx_full",  32'(tx_full),     32'd0);
      check("rst_rx_empty", 32'(rx_empty),    32'd1);
      check("rst_rx_rdata", 32'(rx_rdata),    32'd0);
      check("rst_busy",     32'(busy),        32'd0);
      check("rst_start",    32'(spi_start),   32'd0);
      check("rst_data_in",  32'(spi_data_in), 32'd0);
      check("rst_cs_n",     32'(spi_cs_n),    32'd1);

      for (int i = 0; i < 6; i++) begin
         cs_assert  = cs_tab[i].a;
         cs_release = cs_tab[i].r;
         tick();
         cs_assert  = 1'b0;
         cs_release = 1'b0;
         check($sformatf("cs_vec%0d", i), 32'(spi_cs_n),
               32'(cs_tab[i].exp_cs_n));
      end

      // Single byte loopback and start latency.
      tx_wdata = 8'hA5;
      tx_write = 1'b1;
      tick();
      tx_write = 1'b0;
      check("lat_n1_start", 32'(spi_start), 32'd0);
      tick();
      check("lat_n2_start", 32'(spi_start),   32'd1);
      check("lat_n2_data",  32'(spi_data_in), 32'hA5);
      check("lat_n2_busy",  32'(busy),        32'd1);
      wait_idle("a5_idle", 50);
      check("a5_rx_empty", 32'(rx_empty), 32'd0);
      read_expect("a5_rx", 8'hA5);
      check("a5_single_push", 32'(rx_empty), 32'd1);

      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
      check("empty_read_empty", 32'(rx_empty), 32'd1);
      check("empty_read_rdata", 32'(rx_rdata), 32'd0);

      // Done held four cycles: one push per byte, start gap.
      eng_lat  = 1;
      eng_hold = 4;
      mon_en   = 1'b1;
      tick();
      tx_write = 1'b1;
      tx_wdata = 8'h3C;
      tick();
      tx_wdata = 8'hC3;
      tick();
      tx_write = 1'b0;
      wait_idle("hold_idle", 100);
      for (int i = 0; i < 8; i++) tick();
      check("hold_rises",   32'(mon_rises), 32'd2);
      check("hold_min_gap", 32'(mon_min),   32'd2);
      mon_en = 1'b0;
      read_expect("hold_rx0", 8'h3C);
      read_expect("hold_rx1", 8'hC3);
      check("hold_rx_done", 32'(rx_empty), 32'd1);
      eng_hold = 1;

      // Fill RX with eight bytes.
      for (int i = 0; i < 8; i++) begin
         tx_wdata = fill_tab[i].wdata;
         tx_write = 1'b1;
         tick();
      end
      tx_write = 1'b0;
      wait_idle("fill_idle", 400);
      check("fill_head", 32'(rx_rdata), 32'(fill_tab[0].exp_rx));

      // RX full: queued byte must stall.
      tx_wdata = 8'h55;
      tx_write = 1'b1;
      tick();
      tx_write = 1'b0;
      stalled = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (spi_start) stalled = 1'b0;
         tick();
      end
      check("stall_no_start", 32'(stalled), 32'd1);
      check("stall_busy",     32'(busy),    32'd1);
      read_expect("stall_pop", fill_tab[0].exp_rx);
      wait_start("stall_release", 20);
      check("stall_data", 32'(spi_data_in), 32'h55);
      wait_idle("stall_idle", 50);

      // RX full again, so TX fills up; ninth write dropped.
      for (int i = 1; i <= 8; i++) begin
         tx_wdata = 8'(i);
         tx_write = 1'b1;
         tick();
      end
      check("tx_full_8", 32'(tx_full), 32'd1);
      tx_wdata = 8'hFF;
      tick();
      tx_write = 1'b0;
      check("tx_full_9", 32'(tx_full),   32'd1);
      check("tx_no_pop", 32'(spi_start), 32'd0);

      for (int i = 1; i < 8; i++) drain_q.push_back(fill_tab[i].exp_rx);
      drain_q.push_back(8'h55);
      for (int i = 1; i <= 8; i++) drain_q.push_back(8'(i));
      for (int i = 0; i < 16; i++)
         read_expect($sformatf("drain%0d", i), drain_q[i]);
      wait_idle("drain_idle", 100);
      check("drain_empty", 32'(rx_empty), 32'd1);
      check("drain_rdata", 32'(rx_rdata), 32'd0);
      check("drain_tx",    32'(tx_full),  32'd0);

      // Reset in the middle of a transfer.
      eng_lat   = 20;
      cs_assert = 1'b1;
      tick();
      cs_assert = 1'b0;
      check("mid_cs_low", 32'(spi_cs_n), 32'd0);
      tx_write = 1'b1;
      tx_wdata = 8'h61;
      tick();
      tx_wdata = 8'h62;
      tick();
      tx_wdata = 8'h63;
      tick();
      tx_write = 1'b0;
      wait_start("mid_start", 10);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_start0",   32'(spi_start), 32'd0);
      check("mid_cs_n",     32'(spi_cs_n),  32'd1);
      check("mid_rx_empty", 32'(rx_empty),  32'd1);
      check("mid_busy",     32'(busy),      32'd0);
      check("mid_tx_full",  32'(tx_full),   32'd0);
      for (int i = 0; i < 40; i++) tick();
      check("mid_no_push",  32'(rx_empty),  32'd1);
      check("mid_quiet",    32'(spi_start), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
